// File: rtl/reg_ctrl_defs.sv
// Shared opcode and FSM state definitions for the register control sequencer
// and anything that drives or observes it.
package reg_ctrl_defs;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_CLR  = 3'd1,
        OP_LOAD = 3'd2,
        OP_ADD  = 3'd3,
        OP_SUB  = 3'd4,
        OP_SHR  = 3'd5,
        OP_SHL  = 3'd6,
        OP_ROR  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // CLR and LOAD always take exactly one EXEC cycle; arg is data, not a count.
    function automatic logic op_is_single(input op_e op);
        return (op == OP_CLR) || (op == OP_LOAD);
    endfunction

    function automatic logic op_needs_exec(input op_e op, input logic [3:0] arg);
        logic needs;
        case (op)
            OP_NOP:          needs = 1'b0;
            OP_CLR, OP_LOAD: needs = 1'b1;
            default:         needs = (arg != 4'd0);
        endcase
        return needs;
    endfunction

endpackage

// File: rtl/reg_ctrl_seq.sv
// Command sequencer that turns clear/load/add/sub/shift/rotate commands into
// per-cycle control pulses for a 4-bit register instanced beside it.
module reg_ctrl_seq
    import reg_ctrl_defs::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_arg,
    input  logic       abort,
    input  logic [3:0] reg_val,
    output logic       cl,
    output logic       ld,
    output logic       inc,
    output logic       dec,
    output logic       sr,
    output logic       sl,
    output logic       ir,
    output logic       il,
    output logic [3:0] ld_data,
    output logic       busy,
    output logic       done
);

    state_e     state_q;
    op_e        op_q;
    logic [3:0] arg_q;
    logic [3:0] cnt_q;
    op_e        cmd_op_e;
    logic       last_beat;
    logic       pulse_en;
    logic       unused_reg_bits;

    assign cmd_op_e  = op_e'(cmd_op);
    assign last_beat = op_is_single(op_q) || (cnt_q == 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            arg_q   <= 4'd0;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op_e;
                        arg_q   <= cmd_arg;
                        cnt_q   <= cmd_arg;
                        state_q <= op_needs_exec(cmd_op_e, cmd_arg) ? ST_EXEC : ST_DONE;
                    end
                end
                ST_EXEC: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (abort || last_beat) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // abort kills the current beat's pulse in the same cycle it is seen.
    assign pulse_en = (state_q == ST_EXEC) && !abort;

    assign cl  = pulse_en && (op_q == OP_CLR);
    assign ld  = pulse_en && (op_q == OP_LOAD);
    assign inc = pulse_en && (op_q == OP_ADD);
    assign dec = pulse_en && (op_q == OP_SUB);
    assign sr  = pulse_en && ((op_q == OP_SHR) || (op_q == OP_ROR));
    assign sl  = pulse_en && (op_q == OP_SHL);

    // Rotate right feeds the current LSB back in; plain shifts fill with zero.
    assign ir = pulse_en && (op_q == OP_ROR) && reg_val[0];
    assign il = 1'b0;

    assign ld_data   = ld ? arg_q : 4'd0;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign cmd_ready = (state_q == ST_IDLE);

    assign unused_reg_bits = ^reg_val[3:1];

endmodule
